// File: rtl/seg_display_pkg.sv
// Shared types, segment indices and polarity helpers for the seven-segment scanner.
package seg_display_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBlank = 2'd1,
    StDrive = 2'd2
  } scan_state_e;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Callers truncate the 32-bit result to their own width.
  function automatic logic [31:0] apply_polarity(logic [31:0] value, bit active_low);
    return active_low ? ~value : value;
  endfunction

  function automatic logic [31:0] SEG_OFF(bit active_low);
    return {32{active_low}};
  endfunction

  function automatic logic [31:0] DIG_OFF(bit active_low);
    return {32{active_low}};
  endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Bus between the timer (master) and the display scanner (slave).
interface seg_display_scan_if #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SEG_W      = 7
);
  logic                                en;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]    digit_in;
  logic [SEG_W-1:0]                    seg_out;
  logic [NUM_DIGITS-1:0]               dig_sel;
  logic                                frame_done;

  modport master (
    output en,
    output digit_in,
    input  seg_out,
    input  dig_sel,
    input  frame_done
  );

  modport slave (
    input  en,
    input  digit_in,
    output seg_out,
    output dig_sel,
    output frame_done
  );
endinterface

// File: rtl/seg_scan_counter.sv
// Per-slot cycle counter with terminal flags for the end of the blank and drive phases.
module seg_scan_counter #(
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic blank_end,
  output logic drive_end
);
  localparam int unsigned CntW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DriveCycles = REFRESH_DIV - BLANK_CYCLES;
  localparam logic [CntW-1:0] BlankLast =
      CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CntW-1:0] DriveLast = CntW'(DriveCycles - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge sys_clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // With blanking disabled the blank phase never exists, so its flag stays low.
  assign blank_end = (BLANK_CYCLES > 0) && (cnt_q == BlankLast);
  assign drive_end = (cnt_q == DriveLast);

endmodule

// File: rtl/seg_display_scan.sv
// Six-digit seven-segment scanner: frame snapshot, per-digit blanking, registered pad outputs.
module seg_display_scan
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned SEG_W          = 7,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter bit          ACTIVE_LOW_OUT = 1'b1
) (
  input logic             sys_clk,
  input logic             rst,
  seg_display_scan_if.slave bus
);
  localparam logic [1:0] IDLE  = StIdle;
  localparam logic [1:0] BLANK = StBlank;
  localparam logic [1:0] DRIVE = StDrive;
  localparam logic [1:0] AfterSlot = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  localparam logic [SEG_W-1:0]      SegOff = SEG_W'(SEG_OFF(ACTIVE_LOW_OUT));
  localparam logic [NUM_DIGITS-1:0] DigOff = NUM_DIGITS'(DIG_OFF(ACTIVE_LOW_OUT));

  logic [1:0]                       state_q, state_d;
  logic [IdxW-1:0]                  idx_q, idx_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] frame_buf_q, frame_buf_d;
  logic [SEG_W-1:0]                 seg_q, seg_d;
  logic [NUM_DIGITS-1:0]            dig_q, dig_d;
  logic [NUM_DIGITS-1:0]            onehot;
  logic                             frame_end, frame_pend_q, frame_done_q;
  logic                             cnt_clr, cnt_inc, blank_end, drive_end;

  seg_scan_counter #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_counter (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .clear     (cnt_clr),
    .inc       (cnt_inc),
    .blank_end (blank_end),
    .drive_end (drive_end)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_buf_d = frame_buf_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    frame_end   = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          frame_buf_d = bus.digit_in;
          idx_d       = '0;
          cnt_clr     = 1'b1;
          state_d     = AfterSlot;
        end
        BLANK: begin
          if (blank_end) begin
            cnt_clr = 1'b1;
            state_d = DRIVE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DRIVE: begin
          if (drive_end) begin
            cnt_clr = 1'b1;
            state_d = AfterSlot;
            if (idx_q == IdxLast) begin
              frame_end   = 1'b1;
              idx_d       = '0;
              frame_buf_d = bus.digit_in;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    onehot = NUM_DIGITS'(1) << idx_q;
    seg_d  = SegOff;
    dig_d  = DigOff;
    if (state_q == DRIVE) begin
      seg_d = SEG_W'(apply_polarity(32'(frame_buf_q[idx_q]), ACTIVE_LOW_OUT));
      dig_d = NUM_DIGITS'(apply_polarity(32'(onehot), ACTIVE_LOW_OUT));
    end
  end

  // frame_done is delayed one extra stage so it lines up with the pads going dark.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frame_buf_q  <= '0;
      seg_q        <= SegOff;
      dig_q        <= DigOff;
      frame_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_buf_q  <= frame_buf_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_pend_q <= frame_end;
      frame_done_q <= frame_pend_q;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan: one DUT with 2 blank cycles, one with blanking off.
module tb_seg_display_scan;
  typedef logic [5:0][6:0] pats_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pats_t pat_a = {7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
  pats_t pat_b = {7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h3F};

  always #5 clk = ~clk;

  seg_display_scan_if #(.NUM_DIGITS(6), .SEG_W(7)) bus_b ();
  seg_display_scan_if #(.NUM_DIGITS(6), .SEG_W(7)) bus_n ();

  seg_display_scan #(
    .NUM_DIGITS(6), .SEG_W(7), .REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW_OUT(1'b1)
  ) dut_b (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus_b)
  );

  seg_display_scan #(
    .NUM_DIGITS(6), .SEG_W(7), .REFRESH_DIV(8), .BLANK_CYCLES(0), .ACTIVE_LOW_OUT(1'b1)
  ) dut_n (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus_n)
  );

  // Expected pads t cycles after the edge that first samples en=1 (8-cycle slots, 6 digits).
  function automatic logic [5:0] exp_dig(int t, int blank);
    int u = t - (blank + 1);
    if (u < 0 || (u % 8) >= 8 - blank) return 6'h3F;
    return ~(6'd1 << ((u / 8) % 6));
  endfunction

  function automatic logic [6:0] exp_seg(int t, int blank, pats_t p0, pats_t p1);
    int u = t - (blank + 1);
    pats_t p;
    if (u < 0 || (u % 8) >= 8 - blank) return 7'h7F;
    p = (u / 48 == 0) ? p0 : p1;
    return ~p[(u / 8) % 6];
  endfunction

  function automatic logic exp_fd(int t);
    return (t >= 49) && ((t - 49) % 48 == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fresh();
    bus_b.en = 1'b0;
    bus_n.en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_b.en = 1'b1;
    bus_b.digit_in = pat_a;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 3;
      if (bus_b.seg_out !== 7'h7F) begin
        errors++; $display("FAIL reset seg_out cyc=%0d got %h exp 7f", i, bus_b.seg_out);
      end
      if (bus_b.dig_sel !== 6'h3F) begin
        errors++; $display("FAIL reset dig_sel cyc=%0d got %h exp 3f", i, bus_b.dig_sel);
      end
      if (bus_b.frame_done !== 1'b0) begin
        errors++; $display("FAIL reset frame_done cyc=%0d got %b exp 0", i, bus_b.frame_done);
      end
    end
    rst = 1'b0;
    bus_b.en = 1'b0;
    tick();
  endtask

  task automatic test_basic_scan();
    start_fresh();
    bus_b.digit_in = pat_a;
    bus_b.en = 1'b1;
    tick();
    for (int t = 1; t <= 100; t++) begin
      tick();
      checks += 3;
      if (bus_b.dig_sel !== exp_dig(t, 2)) begin
        errors++; $display("FAIL basic dig_sel t=%0d got %h exp %h", t, bus_b.dig_sel, exp_dig(t, 2));
      end
      if (bus_b.seg_out !== exp_seg(t, 2, pat_a, pat_a)) begin
        errors++;
        $display("FAIL basic seg_out t=%0d got %h exp %h", t, bus_b.seg_out,
                 exp_seg(t, 2, pat_a, pat_a));
      end
      if (bus_b.frame_done !== exp_fd(t)) begin
        errors++; $display("FAIL basic frame_done t=%0d got %b exp %b", t, bus_b.frame_done, exp_fd(t));
      end
    end
    bus_b.en = 1'b0;
  endtask

  task automatic test_snapshot();
    start_fresh();
    bus_b.digit_in = pat_a;
    bus_b.en = 1'b1;
    tick();
    for (int t = 1; t <= 70; t++) begin
      tick();
      checks += 2;
      if (bus_b.seg_out !== exp_seg(t, 2, pat_a, pat_b)) begin
        errors++;
        $display("FAIL snapshot seg_out t=%0d got %h exp %h", t, bus_b.seg_out,
                 exp_seg(t, 2, pat_a, pat_b));
      end
      if (bus_b.frame_done !== exp_fd(t)) begin
        errors++; $display("FAIL snapshot frame_done t=%0d got %b exp %b", t, bus_b.frame_done, exp_fd(t));
      end
      if (t == 20) bus_b.digit_in = pat_b;
    end
    bus_b.en = 1'b0;
  endtask

  task automatic test_en_drop();
    start_fresh();
    bus_b.digit_in = pat_a;
    bus_b.en = 1'b1;
    tick();
    for (int t = 1; t <= 28; t++) tick();
    bus_b.en = 1'b0;
    tick();
    checks++;
    if (bus_b.dig_sel !== exp_dig(29, 2)) begin
      errors++; $display("FAIL en_drop last lit dig_sel got %h exp %h", bus_b.dig_sel, exp_dig(29, 2));
    end
    for (int t = 30; t <= 40; t++) begin
      tick();
      checks += 3;
      if (bus_b.dig_sel !== 6'h3F) begin
        errors++; $display("FAIL en_drop dig_sel t=%0d got %h exp 3f", t, bus_b.dig_sel);
      end
      if (bus_b.seg_out !== 7'h7F) begin
        errors++; $display("FAIL en_drop seg_out t=%0d got %h exp 7f", t, bus_b.seg_out);
      end
      if (bus_b.frame_done !== 1'b0) begin
        errors++; $display("FAIL en_drop frame_done t=%0d got %b exp 0", t, bus_b.frame_done);
      end
    end
    bus_b.en = 1'b1;
    tick();
    for (int t = 1; t <= 60; t++) begin
      tick();
      checks += 2;
      if (bus_b.dig_sel !== exp_dig(t, 2)) begin
        errors++; $display("FAIL en_restart dig_sel t=%0d got %h exp %h", t, bus_b.dig_sel, exp_dig(t, 2));
      end
      if (bus_b.frame_done !== exp_fd(t)) begin
        errors++;
        $display("FAIL en_restart frame_done t=%0d got %b exp %b", t, bus_b.frame_done, exp_fd(t));
      end
    end
    bus_b.en = 1'b0;
  endtask

  task automatic test_mid_reset();
    start_fresh();
    bus_b.digit_in = pat_a;
    bus_b.en = 1'b1;
    tick();
    for (int t = 1; t <= 36; t++) tick();
    rst = 1'b1;
    tick();
    checks += 3;
    if (bus_b.dig_sel !== 6'h3F) begin
      errors++; $display("FAIL mid_reset dig_sel got %h exp 3f", bus_b.dig_sel);
    end
    if (bus_b.seg_out !== 7'h7F) begin
      errors++; $display("FAIL mid_reset seg_out got %h exp 7f", bus_b.seg_out);
    end
    if (bus_b.frame_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset frame_done got %b exp 0", bus_b.frame_done);
    end
    rst = 1'b0;
    tick();
    for (int t = 1; t <= 60; t++) begin
      tick();
      checks += 3;
      if (bus_b.dig_sel !== exp_dig(t, 2)) begin
        errors++; $display("FAIL post_reset dig_sel t=%0d got %h exp %h", t, bus_b.dig_sel, exp_dig(t, 2));
      end
      if (bus_b.seg_out !== exp_seg(t, 2, pat_a, pat_a)) begin
        errors++;
        $display("FAIL post_reset seg_out t=%0d got %h exp %h", t, bus_b.seg_out,
                 exp_seg(t, 2, pat_a, pat_a));
      end
      if (bus_b.frame_done !== exp_fd(t)) begin
        errors++;
        $display("FAIL post_reset frame_done t=%0d got %b exp %b", t, bus_b.frame_done, exp_fd(t));
      end
    end
    bus_b.en = 1'b0;
  endtask

  task automatic test_no_blank();
    start_fresh();
    bus_n.digit_in = pat_a;
    bus_n.en = 1'b1;
    tick();
    for (int t = 1; t <= 100; t++) begin
      tick();
      checks += 3;
      if (bus_n.dig_sel !== exp_dig(t, 0)) begin
        errors++; $display("FAIL no_blank dig_sel t=%0d got %h exp %h", t, bus_n.dig_sel, exp_dig(t, 0));
      end
      if (bus_n.seg_out !== exp_seg(t, 0, pat_a, pat_a)) begin
        errors++;
        $display("FAIL no_blank seg_out t=%0d got %h exp %h", t, bus_n.seg_out,
                 exp_seg(t, 0, pat_a, pat_a));
      end
      if (bus_n.frame_done !== exp_fd(t)) begin
        errors++;
        $display("FAIL no_blank frame_done t=%0d got %b exp %b", t, bus_n.frame_done, exp_fd(t));
      end
    end
    bus_n.en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus_b.en = 1'b0;
    bus_b.digit_in = '0;
    bus_n.en = 1'b0;
    bus_n.digit_in = '0;
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_en_drop();
    test_mid_reset();
    test_no_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Time-multiplexed scanner for a six-digit seven-segment display. Sits directly downstream of the digital timer: consumes its six parallel segment patterns and drives one shared segment bus plus per-digit enables, one digit at a time. Per-frame snapshot prevents tearing. Blanking gaps between digits suppress ghosting.

## Interface
- NUM_DIGITS, 6: digits scanned per frame.
- SEG_W, 7: segment bits per digit; bit0=a … bit6=g.
- REFRESH_DIV, 1000: sys_clk cycles per digit slot, including blanking; must be > BLANK_CYCLES.
- BLANK_CYCLES, 2: cycles per slot with all digits off; 0 disables blanking.
- ACTIVE_LOW_OUT, 1: 1 inverts seg_out and dig_sel for common-anode pads, so off means all ones.
- sys_clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset; takes priority over every other input.
- en  in  1  scan enable, level sensitive.
- digit_in  in  [NUM_DIGITS-1:0][SEG_W-1:0]  segment patterns; 1 means segment lit. Index 0 is the rightmost digit.
- seg_out  out  SEG_W  shared segment bus, polarity per ACTIVE_LOW_OUT.
- dig_sel  out  NUM_DIGITS  one-hot digit enable, polarity per ACTIVE_LOW_OUT.
- frame_done  out  1  one-cycle pulse at the end of each complete frame.

## Operation
- Internal state:
  - FSM: IDLE, BLANK, DRIVE.
  - Digit index idx, width $clog2(NUM_DIGITS).
  - Slot counter cnt, width $clog2(REFRESH_DIV).
  - Frame buffer buf, NUM_DIGITS×SEG_W.
- DRIVE_CYCLES = REFRESH_DIV − BLANK_CYCLES.
- IDLE:
  - Outputs off.
  - en=1: capture buf ← digit_in, idx←0, cnt←0. Go to BLANK, or to DRIVE if BLANK_CYCLES=0.
- BLANK:
  - Outputs off; cnt increments.
  - At cnt==BLANK_CYCLES−1: cnt←0, go to DRIVE.
- DRIVE:
  - seg_out = buf[idx]; dig_sel = one-hot(idx). Polarity applied on both.
  - At cnt==DRIVE_CYCLES−1 with idx<NUM_DIGITS−1: idx++, cnt←0, go to BLANK (or stay in DRIVE if BLANK_CYCLES=0).
  - At cnt==DRIVE_CYCLES−1 with idx==NUM_DIGITS−1: frame_done pulses, idx←0, buf ← digit_in (recapture), cnt←0, go to BLANK (or DRIVE).
- en=0 in any state: next state is IDLE. cnt and idx clear; buf holds its contents.
- Snapshot rule: digit_in changes are invisible until the next capture. Capture happens only on IDLE exit or at frame end.
- Idx wrap: only via the frame-end path; idx never exceeds NUM_DIGITS−1.

## Timing
- Reset values:
  - FSM IDLE; idx=0; cnt=0; buf=0.
  - seg_out and dig_sel off: all ones if ACTIVE_LOW_OUT=1, else all zeros.
  - frame_done=0.
- Outputs are registered and lag the FSM by exactly one cycle (glitch-free pads).
- en sampled high at edge N: FSM enters BLANK at N. The first dig_sel assertion appears after edge N+BLANK_CYCLES+1.
- Each digit is lit for exactly DRIVE_CYCLES cycles, followed by exactly BLANK_CYCLES dark cycles.
- Frame period is exactly NUM_DIGITS×REFRESH_DIV cycles.
- frame_done is high for the one cycle following the last DRIVE cycle of digit NUM_DIGITS−1, aligned with the registered outputs going off.
- en falling: outputs off one cycle after the edge that samples en=0. frame_done is not generated for a partial frame.
- rst mid-frame: all outputs at reset values after that edge. After release, a fresh capture and scan start from digit 0 if en=1.
- rst and en both high: rst wins.

## Structure
- Package seg_display_pkg holds:
  - State enum typedef (IDLE/BLANK/DRIVE).
  - Segment index constants SEG_A…SEG_G.
  - Function applying output polarity.
  - SEG_OFF / DIG_OFF constant generators.
- One natural sub-module: seg_scan_counter, the slot counter with terminal-count flags for the BLANK and DRIVE ends.
- FSM, buffer and output registers stay in the top module.

## Test plan
Test plan bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=6, ACTIVE_LOW_OUT=1.
- Reset: rst high for 3 cycles with en=1 → seg_out=7'h7F, dig_sel=6'h3F, frame_done=0 throughout.
- Basic scan:
  - Stimulus: digit_in = {7'h7D,7'h6D,7'h66,7'h4F,7'h5B,7'h06} (digit5…digit0); en rises.
  - First lit slot: dig_sel=6'h3E with seg_out=7'h79 for 6 cycles, then 2 cycles at 6'h3F.
  - Next slot: dig_sel=6'h3D with seg_out=7'h24.
  - frame_done pulses every 48 cycles.
- Snapshot: change digit0 to 7'h3F while digit 2 is lit → digit 0 still shows 7'h79 for the rest of that frame and shows 7'h40 only after frame_done.
- Enable drop: en low during digit 3 DRIVE → outputs off next cycle, no frame_done. en high again → restart with 2 blank cycles, then digit 0.
- Mid-frame reset: rst for 1 cycle during digit 4 with en held high → outputs off immediately; scan resumes at digit 0 after 2 blank cycles, with no frame_done for the aborted frame.
- No blanking (BLANK_CYCLES=0): dig_sel steps 6'h3E→6'h3D→… every 8 cycles with no all-off gap; frame period is 48 cycles.
